// File: rtl/rle_spi_pkg.sv
// Shared state encodings, opcodes and sizes for the RLE SPI flash responder.
// RLE_SPI_FAST_READ_EN additionally enables acceptance of the 0x0B fast-read opcode.
package rle_spi_pkg;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE   = 3'd0;
    localparam spi_state_t ST_CMD    = 3'd1;
    localparam spi_state_t ST_ADDR   = 3'd2;
    localparam spi_state_t ST_DUMMY  = 3'd3;
    localparam spi_state_t ST_DATA   = 3'd4;
    localparam spi_state_t ST_IGNORE = 3'd5;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int SPI_ADDR_BITS = 24;

    function automatic logic opcode_accepted(input logic [7:0] opcode,
                                             input logic [7:0] read_cmd);
        logic ok;
        ok = (opcode == read_cmd);
`ifdef RLE_SPI_FAST_READ_EN
        ok = ok || (opcode == CMD_FAST_READ);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/rle_spi_responder_sync.sv
// Two-flop synchroniser for one SPI pin with rise/fall pulses of the synchronised level.
// Provides module spi_pin_sync; RESET_VAL selects the level the chain resets to.
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pin;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/rle_spi_responder.sv
// SPI flash read responder serving bytes from an on-chip memory to the RLE VGA core.
// Define RLE_SPI_FAST_READ_EN to also accept opcode 0x0B followed by 8 dummy clocks.
module rle_spi_responder
    import rle_spi_pkg::*;
#(
    parameter int         MEM_AW   = 10,
    parameter logic [7:0] READ_CMD = CMD_READ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              active
);

    localparam logic [4:0] CMD_LAST  = 5'd7;
    localparam logic [4:0] ADDR_LAST = 5'(SPI_ADDR_BITS - 1);
    localparam logic [4:0] BYTE_LAST = 5'd7;

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    // CS resets to "asserted" so a transfer already running at reset release never yields a fall.
    spi_pin_sync #(.RESET_VAL(1'b0)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (spi_cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (spi_clk),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (spi_mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_sync = ^{cs_level, sck_level, mosi_rise, mosi_fall};

    spi_state_t        state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        cmd_sr_q, cmd_sr_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [6:0]        tx_sr_q, tx_sr_d;
    logic [7:0]        hold_q, hold_d;
    logic              miso_q, miso_d;
    logic              mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              rd_pend_q, rd_pend_d;
`ifdef RLE_SPI_FAST_READ_EN
    logic              fast_q, fast_d;
`endif

    logic [7:0]        opcode;
    logic [MEM_AW-1:0] addr_shift;
    logic [MEM_AW-1:0] addr_next;

    assign opcode     = {cmd_sr_q, mosi_level};
    assign addr_shift = {addr_q[MEM_AW-2:0], mosi_level};
    assign addr_next  = addr_q + MEM_AW'(1);

    // addr_q always names the byte sitting in hold_q; the shift register load consumes it and prefetches the next.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_sr_d   = cmd_sr_q;
        addr_d     = addr_q;
        tx_sr_d    = tx_sr_q;
        hold_d     = hold_q;
        miso_d     = miso_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        rd_pend_d  = mem_rd_q;
`ifdef RLE_SPI_FAST_READ_EN
        fast_d     = fast_q;
`endif

        if (rd_pend_q) begin
            hold_d = mem_data;
        end

        if (cs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 5'd0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        cmd_sr_d  = opcode[6:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == CMD_LAST) begin
                            bit_cnt_d = 5'd0;
                            if (opcode_accepted(opcode, READ_CMD)) begin
                                state_d = ST_ADDR;
`ifdef RLE_SPI_FAST_READ_EN
                                fast_d  = (opcode != READ_CMD);
`endif
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr_d    = addr_shift;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == ADDR_LAST) begin
                            bit_cnt_d  = 5'd0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_shift;
`ifdef RLE_SPI_FAST_READ_EN
                            state_d    = fast_q ? ST_DUMMY : ST_DATA;
`else
                            state_d    = ST_DATA;
`endif
                        end
                    end
                end
`ifdef RLE_SPI_FAST_READ_EN
                ST_DUMMY: begin
                    miso_d = 1'b0;
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == BYTE_LAST) begin
                            bit_cnt_d = 5'd0;
                            state_d   = ST_DATA;
                        end
                    end
                end
`endif
                ST_DATA: begin
                    if (sck_fall) begin
                        if (bit_cnt_q == 5'd0) begin
                            miso_d     = hold_q[7];
                            tx_sr_d    = hold_q[6:0];
                            addr_d     = addr_next;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_next;
                            bit_cnt_d  = 5'd1;
                        end else begin
                            miso_d    = tx_sr_q[6];
                            tx_sr_d   = {tx_sr_q[5:0], 1'b0};
                            bit_cnt_d = (bit_cnt_q == BYTE_LAST) ? 5'd0 : bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 5'd0;
                    miso_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 5'd0;
            cmd_sr_q   <= 7'd0;
            addr_q     <= '0;
            tx_sr_q    <= 7'd0;
            hold_q     <= 8'd0;
            miso_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rd_pend_q  <= 1'b0;
`ifdef RLE_SPI_FAST_READ_EN
            fast_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_sr_q   <= cmd_sr_d;
            addr_q     <= addr_d;
            tx_sr_q    <= tx_sr_d;
            hold_q     <= hold_d;
            miso_q     <= miso_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            rd_pend_q  <= rd_pend_d;
`ifdef RLE_SPI_FAST_READ_EN
            fast_q     <= fast_d;
`endif
        end
    end

    assign spi_miso = miso_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign active   = (state_q != ST_IDLE) && (state_q != ST_IGNORE);

endmodule

// File: tb/tb_rle_spi_responder.sv
// Directed bench for rle_spi_responder: memory byte i holds i ^ 8'h5A, SCK runs at clk/8.
// Honours RLE_SPI_FAST_READ_EN to pick the expected fast-read outcome.
module tb_rle_spi_responder;

    localparam int MEM_AW = 10;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              spi_cs   = 1'b1;
    logic              spi_clk  = 1'b0;
    logic              spi_mosi = 1'b0;
    logic              spi_miso;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_data = 8'h00;
    logic              active;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [MEM_AW-1:0] rdLog[$];

    typedef struct {
        string       name;
        logic [7:0]  opcode;
        logic [23:0] addr;
        logic [31:0] expData;
        logic        expRd;
        logic [9:0]  firstRd;
        logic        expActive;
    } vec_t;

    vec_t vecs[5];

    rle_spi_responder #(.MEM_AW(MEM_AW), .READ_CMD(8'h03)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs   (spi_cs),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .active   (active)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data appears one clock after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr[7:0] ^ 8'h5A;
    end

    always @(negedge clk) begin
        if (mem_rd) rdLog.push_back(mem_addr);
    end

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic spiByte(input logic [7:0] txByte, output logic [7:0] rxByte);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = txByte[i];
            waitClk(4);
            spi_clk   = 1'b1;
            rxByte[i] = spi_miso;
            waitClk(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spiBits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = 1'b0;
            waitClk(4);
            spi_clk = 1'b1;
            waitClk(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic csLow();
        spi_cs = 1'b0;
        waitClk(8);
    endtask

    task automatic csHigh();
        waitClk(4);
        spi_cs = 1'b1;
        waitClk(10);
    endtask

    task automatic applyStimulus(input vec_t v, output logic [31:0] rxData, output logic activeAfterOp);
        logic [7:0] rx;
        csLow();
        spiByte(v.opcode, rx);
        waitClk(2);
        activeAfterOp = active;
        spiByte(v.addr[23:16], rx);
        spiByte(v.addr[15:8], rx);
        spiByte(v.addr[7:0], rx);
        for (int b = 0; b < 4; b++) begin
            spiByte(8'h00, rx);
            rxData[31-8*b -: 8] = rx;
        end
    endtask

    initial begin
        logic [31:0] rxData;
        logic        actOp;
        logic [7:0]  rx;
        logic [9:0]  expAddr;

        vecs[0] = '{"read_0x10",  8'h03, 24'h000010, 32'h4A4B4849, 1'b1, 10'h010, 1'b1};
        vecs[1] = '{"wrap_0x3FE", 8'h03, 24'hFF03FE, 32'hA4A55A5B, 1'b1, 10'h3FE, 1'b1};
        vecs[2] = '{"bad_op_9F",  8'h9F, 24'h000000, 32'h00000000, 1'b0, 10'h000, 1'b0};
        vecs[3] = '{"read_0x20",  8'h03, 24'h000020, 32'h7A7B7879, 1'b1, 10'h020, 1'b1};
        vecs[4] = '{"high_bits",  8'h03, 24'hABCD12, 32'h48494E4F, 1'b1, 10'h112, 1'b1};

        waitClk(3);
        checkOutput("rst_miso", {31'd0, spi_miso}, 32'd0);
        checkOutput("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        checkOutput("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;
        waitClk(6);
        checkOutput("post_rst_miso", {31'd0, spi_miso}, 32'd0);
        checkOutput("post_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        checkOutput("post_rst_active", {31'd0, active}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            rdLog.delete();
            applyStimulus(vecs[v], rxData, actOp);
            csHigh();
            checkOutput({vecs[v].name, "_data"}, rxData, vecs[v].expData);
            checkOutput({vecs[v].name, "_active_op"}, {31'd0, actOp}, {31'd0, vecs[v].expActive});
            if (vecs[v].expRd) begin
                checkOutput({vecs[v].name, "_rd_count"}, {31'd0, rdLog.size() >= 4}, 32'd1);
                if (rdLog.size() >= 4) begin
                    for (int k = 0; k < 4; k++) begin
                        expAddr = vecs[v].firstRd + 10'(k);
                        checkOutput({vecs[v].name, "_rd_addr"}, {22'd0, rdLog[k]}, {22'd0, expAddr});
                    end
                end
            end else begin
                checkOutput({vecs[v].name, "_no_rd"}, rdLog.size(), 32'd0);
            end
            checkOutput({vecs[v].name, "_idle_active"}, {31'd0, active}, 32'd0);
            checkOutput({vecs[v].name, "_idle_miso"}, {31'd0, spi_miso}, 32'd0);
        end

        // Abort after 3 bits of the second byte, then a fresh read must start cleanly.
        csLow();
        spiByte(8'h03, rx);
        spiByte(8'h00, rx);
        spiByte(8'h00, rx);
        spiByte(8'h40, rx);
        spiByte(8'h00, rx);
        checkOutput("abort_first_byte", {24'd0, rx}, 32'h1A);
        spiBits(3);
        csHigh();
        checkOutput("abort_miso_low", {31'd0, spi_miso}, 32'd0);
        csLow();
        spiByte(8'h03, rx);
        spiByte(8'h00, rx);
        spiByte(8'h00, rx);
        spiByte(8'h20, rx);
        spiByte(8'h00, rx);
        checkOutput("restart_byte0", {24'd0, rx}, 32'h7A);
        spiByte(8'h00, rx);
        checkOutput("restart_byte1", {24'd0, rx}, 32'h7B);
        csHigh();

        // Reset mid-transfer: outputs clear at once, and the running transfer stays ignored.
        csLow();
        spiByte(8'h03, rx);
        spiByte(8'h00, rx);
        waitClk(1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_miso", {31'd0, spi_miso}, 32'd0);
        checkOutput("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
        checkOutput("midrst_active", {31'd0, active}, 32'd0);
        checkOutput("midrst_mem_addr", {22'd0, mem_addr}, 32'd0);
        waitClk(3);
        rst_n = 1'b1;
        rdLog.delete();
        spiByte(8'h00, rx);
        spiByte(8'h10, rx);
        spiByte(8'h00, rx);
        rxData[15:8] = rx;
        spiByte(8'h00, rx);
        rxData[7:0] = rx;
        checkOutput("midrst_data", {16'd0, rxData[15:0]}, 32'd0);
        checkOutput("midrst_active_after", {31'd0, active}, 32'd0);
        checkOutput("midrst_no_rd", rdLog.size(), 32'd0);
        csHigh();

        // Fast read with 8 dummy clocks.
        rdLog.delete();
        csLow();
        spiByte(8'h0B, rx);
        spiByte(8'h00, rx);
        spiByte(8'h00, rx);
        spiByte(8'h05, rx);
        spiByte(8'h00, rx);
        checkOutput("fast_dummy_miso", {24'd0, rx}, 32'd0);
        spiByte(8'h00, rx);
        rxData[15:8] = rx;
        spiByte(8'h00, rx);
        rxData[7:0] = rx;
        csHigh();
`ifdef RLE_SPI_FAST_READ_EN
        checkOutput("fast_data", {16'd0, rxData[15:0]}, 32'h5F5C);
        checkOutput("fast_rd_count", {31'd0, rdLog.size() >= 1}, 32'd1);
        if (rdLog.size() >= 1) checkOutput("fast_first_rd", {22'd0, rdLog[0]}, 32'h005);
`else
        checkOutput("fast_off_data", {16'd0, rxData[15:0]}, 32'h0000);
        checkOutput("fast_off_no_rd", rdLog.size(), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/rle_spi_responder.md
# rle_spi_responder

Synthesizable SPI flash responder that serves bytes from an on-chip byte memory to the RLE VGA core's SPI read initiator. It answers the serial read command with a 24-bit address and streams data MSB-first, auto-incrementing, until chip select deasserts. It sits on the far side of the core's `uio` SPI pins and replaces an external flash for self-test and emulation builds. All SPI inputs are oversampled in the system clock domain.

## Interface
Parameters:
- `MEM_AW`, default 10: memory address width. Uses the low `MEM_AW` bits of the received 24-bit address.
- `READ_CMD`, default 8'h03: opcode for the read command.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `spi_cs`  in  1  chip select, active-low, asynchronous to `clk`.
- `spi_clk`  in  1  SPI clock, mode 0, asynchronous to `clk`.
- `spi_mosi`  in  1  serial data in from the initiator.
- `spi_miso`  out  1  serial data out to the initiator.
- `mem_rd`  out  1  one-cycle memory read strobe.
- `mem_addr`  out  MEM_AW  memory read address, valid while `mem_rd` is high.
- `mem_data`  in  8  read data, valid exactly 1 clk after `mem_rd`.
- `active`  out  1  high while chip select is asserted and the block has not moved to IGNORE.

## Operation
- `spi_cs`, `spi_clk` and `spi_mosi` each pass through a 2-flop synchroniser. The block detects rising and falling edges of the synchronised `spi_clk`.
- `spi_mosi` is sampled on SCK rise. `spi_miso` changes on SCK fall (mode 0).
- States:
  - IDLE: `spi_cs` high. Synchronised CS falling → CMD, and the bit counter clears.
  - CMD: shift in 8 bits. Opcode == `READ_CMD` → ADDR; any other opcode → IGNORE.
  - ADDR: shift in 24 bits, MSB first. On the 24th rise, `addr_q` is loaded and a fetch is issued → DATA.
  - DATA: on the first SCK fall of each byte, the prefetched byte goes into the output shift register and bit 7 is driven. Bits 6..0 follow on later falls. When the shift register loads, the block fetches `addr_q+1` into a hold register and `addr_q` increments.
  - IGNORE: `spi_miso`=0. No fetches. Exits only when CS goes high.
- A synchronised CS rise in any state → IDLE on the next clk, and `spi_miso`→0. A partial byte is discarded.
- Address arithmetic is modulo 2^MEM_AW. Address all-ones is followed by address 0.
- Address bits above `MEM_AW` are received and ignored.
- At most one `mem_rd` is outstanding. The hold register is always valid before the next byte boundary.

## Timing
- f_clk ≥ 8 × f_sck is a requirement. Edge detection lags the pin by 3 clk.
- Reset values: `spi_miso`=0, `mem_rd`=0, `mem_addr`=0, `active`=0, state=IDLE, counters=0.
- Reset asserted mid-transfer takes effect immediately on all of the above. After release, the block waits in IDLE for a fresh CS fall. A transfer already in progress when reset releases is ignored until CS goes high.
- Fetch latency: `mem_rd` asserts 1 clk after the detected 32nd rise, and `mem_data` is captured the following clk. The first data bit appears on the first detected fall after the 32nd rise.
- If an SCK edge and a CS rise are detected in the same clk, CS rise wins and the edge is ignored.

## Configuration
- `RLE_SPI_FAST_READ_EN` defined: opcode 8'h0B is also accepted. ADDR is followed by a DUMMY state of 8 SCK cycles with `spi_miso`=0, then DATA. The initial fetch is issued at the end of ADDR.
- Not defined: 8'h0B → IGNORE, and the DUMMY state is not synthesised.

## Structure
- Package `rle_spi_pkg` holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, DATA, IGNORE);
  - `CMD_READ`=8'h03 and `CMD_FAST_READ`=8'h0B;
  - `SPI_ADDR_BITS`=24.
- One sub-module, `spi_pin_sync`: a 2-flop synchroniser plus rise/fall pulse generation for a single pin, instantiated once each for cs, sck and mosi.
- The FSM, shift registers, address counter and prefetch hold register live in the top.

## Test plan
- Reset with `spi_cs` high, then release → `spi_miso`=0, `mem_rd`=0, `active`=0.
- Memory holds byte i = i ^ 8'h5A. Send 03 00 00 10 and clock 4 bytes at f_clk/8 → MISO gives 4A 4B 48 49, and `mem_addr` steps 0x10→0x13.
- With `MEM_AW`=10, send 03 FF 03 FE and read 4 bytes → data from addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Send opcode 8'h9F and clock 16 more bits → `spi_miso` stays 0, no `mem_rd`, `active` drops after opcode.
- Raise CS after 3 bits of the second data byte, then start a new 03 read at 0x20 → the first byte out is mem[0x20]. No stale bits appear.
- With `RLE_SPI_FAST_READ_EN`: send 0B 00 00 05 + 8 dummy clocks → the first byte is mem[5]. Without the macro, the same sequence → MISO stays 0.
